// File: rtl/cp0_exc_unit_if.sv
// CP0 exception-unit bus: M-stage exception chain, mtc0/mfc0 access and NPC redirect outputs.
interface cp0_exc_unit_if;
  logic        ExcGotIn;
  logic [4:0]  ExcCodeIn;
  logic [31:0] PCIn;
  logic        BDIn;
  logic [5:0]  HWInt;
  logic        WE;
  logic [4:0]  Addr;
  logic [31:0] WD;
  logic        EXLClr;
  logic [31:0] RD;
  logic        Req;
  logic [31:0] EPCOut;
  logic [31:0] HandlerOut;

  modport master (
    output ExcGotIn, ExcCodeIn, PCIn, BDIn, HWInt, WE, Addr, WD, EXLClr,
    input  RD, Req, EPCOut, HandlerOut
  );

  modport slave (
    input  ExcGotIn, ExcCodeIn, PCIn, BDIn, HWInt, WE, Addr, WD, EXLClr,
    output RD, Req, EPCOut, HandlerOut
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception responder: SR/Cause/EPC/PRId, take decision and pipeline redirect.
// Optional macro CP0_EPC_FWD_EN forwards an mtc0 EPC write onto EPCOut in the same cycle.
module cp0_exc_unit #(
  parameter logic [31:0] PRID_VAL     = 32'h2020_0712,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input logic         clk,
  input logic         reset_n,
  cp0_exc_unit_if.slave bus
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [4:0]  taken_code;
  logic [31:0] pc_aligned;
  logic [31:0] epc_take;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic        wr_sr;
  logic        wr_epc;

  assign int_req    = (|(bus.HWInt & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req    = bus.ExcGotIn & ~sr_exl;
  assign req        = int_req | exc_req;
  assign taken_code = int_req ? 5'd0 : bus.ExcCodeIn;

  // Delay-slot victims return to the branch; subtraction wraps mod 2^32.
  assign pc_aligned = bus.PCIn & ~32'd3;
  assign epc_take   = bus.BDIn ? (pc_aligned - 32'd4) : pc_aligned;

  assign wr_sr  = bus.WE && (bus.Addr == 5'd12) && !req;
  assign wr_epc = bus.WE && (bus.Addr == 5'd14) && !req;

  assign sr_word    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
  assign cause_word = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= bus.HWInt;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_exc <= taken_code;
        cause_bd  <= bus.BDIn;
        epc       <= epc_take;
      end else begin
        // An SR write owns the EXL bit even when eret is in the same stage.
        if (wr_sr) begin
          sr_im  <= bus.WD[15:10];
          sr_exl <= bus.WD[1];
          sr_ie  <= bus.WD[0];
        end else if (bus.EXLClr) begin
          sr_exl <= 1'b0;
        end
        if (wr_epc) begin
          epc <= {bus.WD[31:2], 2'b00};
        end
      end
    end
  end

  always_comb begin
    bus.RD = '0;
    case (bus.Addr)
      5'd12:   bus.RD = sr_word;
      5'd13:   bus.RD = cause_word;
      5'd14:   bus.RD = epc;
      5'd15:   bus.RD = PRID_VAL;
      default: bus.RD = '0;
    endcase
  end

`ifdef CP0_EPC_FWD_EN
  assign bus.EPCOut = wr_epc ? {bus.WD[31:2], 2'b00} : epc;
`else
  assign bus.EPCOut = epc;
`endif

  assign bus.Req        = req;
  assign bus.HandlerOut = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed scoreboard bench for cp0_exc_unit: takes, priority, masking, mtc0, eret and async reset.
module tb_cp0_exc_unit;

  localparam logic [31:0] PRID = 32'h2020_0712;
  localparam logic [31:0] HNDL = 32'h0000_4180;

  logic clk;
  logic reset_n;
  int   ntests;
  int   nfail;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;
  sb_t sb[$];

  cp0_exc_unit_if bus ();

  cp0_exc_unit #(
    .PRID_VAL     (PRID),
    .HANDLER_ADDR (HNDL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [31:0] val);
    sb_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t e;
    ntests++;
    if (sb.size() == 0) begin
      nfail++;
      $error("FAIL sb_empty: got %h expected queued entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        nfail++;
        $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.Addr = a;
    #1;
    d = bus.RD;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    ntests = 0;
    nfail  = 0;
    reset_n       = 1'b0;
    bus.ExcGotIn  = 1'b0;
    bus.ExcCodeIn = '0;
    bus.PCIn      = '0;
    bus.BDIn      = 1'b0;
    bus.HWInt     = '0;
    bus.WE        = 1'b0;
    bus.Addr      = '0;
    bus.WD        = '0;
    bus.EXLClr    = 1'b0;
    cyc();
    cyc();

    // Reset state
    push("rst_sr", 32'h0);      rd(5'd12, d); check(d);
    push("rst_cause", 32'h0);   rd(5'd13, d); check(d);
    push("rst_epc", 32'h0);     rd(5'd14, d); check(d);
    push("rst_prid", PRID);     rd(5'd15, d); check(d);
    push("rst_other", 32'h0);   rd(5'd3, d);  check(d);
    push("rst_req", 32'h0);     check({31'b0, bus.Req});
    push("rst_epcout", 32'h0);  check(bus.EPCOut);
    push("handler", HNDL);      check(bus.HandlerOut);
    reset_n = 1'b1;
    cyc();

    // 1: Ov exception, not in delay slot
    bus.ExcGotIn = 1'b1; bus.ExcCodeIn = 5'd12; bus.PCIn = 32'h3008; bus.BDIn = 1'b0;
    push("t1_req", 32'h1); #1; check({31'b0, bus.Req});
    push("t1_cause", 32'h0000_0030);
    push("t1_epc", 32'h3008);
    push("t1_sr", 32'h2);
    push("t1_epcout", 32'h3008);
    cyc();
    bus.ExcGotIn = 1'b0;
    rd(5'd13, d); check(d);
    rd(5'd14, d); check(d);
    rd(5'd12, d); check(d);
    check(bus.EPCOut);

    // EXL masks a new ExcGotIn
    bus.ExcGotIn = 1'b1; bus.ExcCodeIn = 5'd10; bus.PCIn = 32'h3100;
    push("exl_mask_req", 32'h0); #1; check({31'b0, bus.Req});
    push("exl_mask_cause", 32'h0000_0030);
    push("exl_mask_epc", 32'h3008);
    cyc();
    bus.ExcGotIn = 1'b0;
    rd(5'd13, d); check(d);
    rd(5'd14, d); check(d);

    // eret then 2: AdEL in delay slot
    bus.EXLClr = 1'b1;
    push("eret_sr", 32'h0);
    cyc();
    bus.EXLClr = 1'b0;
    rd(5'd12, d); check(d);
    bus.ExcGotIn = 1'b1; bus.ExcCodeIn = 5'd4; bus.PCIn = 32'h3010; bus.BDIn = 1'b1;
    push("t2_cause", 32'h8000_0010);
    push("t2_epc", 32'h300C);
    cyc();
    bus.ExcGotIn = 1'b0; bus.BDIn = 1'b0;
    rd(5'd13, d); check(d);
    rd(5'd14, d); check(d);

    // PC wrap in delay slot
    bus.EXLClr = 1'b1;
    cyc();
    bus.EXLClr = 1'b0;
    bus.ExcGotIn = 1'b1; bus.ExcCodeIn = 5'd10; bus.PCIn = 32'h0; bus.BDIn = 1'b1;
    push("wrap_epc", 32'hFFFF_FFFC);
    push("wrap_cause", 32'h8000_0028);
    cyc();
    bus.ExcGotIn = 1'b0; bus.BDIn = 1'b0;
    rd(5'd14, d); check(d);
    rd(5'd13, d); check(d);

    // 3: SR write while EXL=1, then interrupt beats exception
    bus.WE = 1'b1; bus.Addr = 5'd12; bus.WD = 32'hFFFF_0401;
    push("t3_sr_wr", 32'h0000_0401);
    cyc();
    bus.WE = 1'b0;
    rd(5'd12, d); check(d);
    bus.HWInt = 6'b000001; bus.ExcGotIn = 1'b1; bus.ExcCodeIn = 5'd5; bus.PCIn = 32'h3020;
    push("t3_req", 32'h1); #1; check({31'b0, bus.Req});
    push("t3_req_masked", 32'h0);
    push("t3_cause", 32'h0000_0400);
    push("t3_epc", 32'h3020);
    push("t3_sr", 32'h0000_0403);
    cyc();
    bus.ExcGotIn = 1'b0;
    check({31'b0, bus.Req});
    rd(5'd13, d); check(d);
    rd(5'd14, d); check(d);
    rd(5'd12, d); check(d);

    // 4: eret with interrupt still pending
    bus.EXLClr = 1'b1;
    push("t4_req_before", 32'h0); #1; check({31'b0, bus.Req});
    push("t4_req_after", 32'h1);
    cyc();
    bus.EXLClr = 1'b0;
    check({31'b0, bus.Req});
    cyc();
    bus.HWInt = '0;

    // WE beats EXLClr on the EXL bit
    bus.WE = 1'b1; bus.Addr = 5'd12; bus.WD = 32'h0000_0403; bus.EXLClr = 1'b1;
    push("we_vs_eret", 32'h0000_0403);
    cyc();
    bus.WE = 1'b0; bus.EXLClr = 1'b0;
    rd(5'd12, d); check(d);

    // Req beats WE: clear SR, then exception with a simultaneous EPC write
    bus.WE = 1'b1; bus.Addr = 5'd12; bus.WD = 32'h0;
    cyc();
    bus.ExcGotIn = 1'b1; bus.ExcCodeIn = 5'd12; bus.PCIn = 32'h3100;
    bus.Addr = 5'd14; bus.WD = 32'h5000;
    push("req_vs_we_epc", 32'h3100);
    cyc();
    bus.ExcGotIn = 1'b0; bus.WE = 1'b0;
    rd(5'd14, d); check(d);

    // 5: mtc0 EPC with low bits forced to zero
    bus.WE = 1'b1; bus.Addr = 5'd14; bus.WD = 32'h0000_4003;
`ifdef CP0_EPC_FWD_EN
    push("t5_epcout_same", 32'h4000);
`else
    push("t5_epcout_same", 32'h3100);
`endif
    #1; check(bus.EPCOut);
    push("t5_epcout_next", 32'h4000);
    push("t5_epc", 32'h4000);
    cyc();
    bus.WE = 1'b0;
    check(bus.EPCOut);
    rd(5'd14, d); check(d);

    // Writes to Cause and PRId are ignored
    bus.WE = 1'b1; bus.Addr = 5'd13; bus.WD = 32'hFFFF_FFFF;
    cyc();
    bus.Addr = 5'd15;
    cyc();
    bus.WE = 1'b0;
    push("cause_ro", 32'h0000_0030); rd(5'd13, d); check(d);
    push("prid_ro", PRID);           rd(5'd15, d); check(d);

    // 6: async reset mid-cycle while EXL=1
    bus.WE = 1'b1; bus.Addr = 5'd14; bus.WD = 32'h3000;
    cyc();
    bus.WE = 1'b0;
    push("t6_pre_epc", 32'h3000); rd(5'd14, d); check(d);
    reset_n = 1'b0;
    push("t6_sr", 32'h0);
    push("t6_cause", 32'h0);
    push("t6_epc", 32'h0);
    rd(5'd12, d); check(d);
    rd(5'd13, d); check(d);
    rd(5'd14, d); check(d);
    bus.ExcGotIn = 1'b1; bus.ExcCodeIn = 5'd12; bus.PCIn = 32'h3200;
    push("t6_req_discard_cause", 32'h0);
    push("t6_req_discard_epc", 32'h0);
    cyc();
    rd(5'd13, d); check(d);
    rd(5'd14, d); check(d);
    bus.ExcGotIn = 1'b0;
    reset_n = 1'b1;
    cyc();

    if (sb.size() != 0) begin
      ntests++;
      nfail++;
      $error("FAIL sb_leftover: got %0d expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
